// File: rtl/axis_m_pkg.sv
// Shared types and constants for the axis_m single-beat AXI4-Stream master.
package axis_m_pkg;

  localparam int unsigned DefaultDataWidth = 32;

  // Transfer sequencing: capture a word, wait for send to drop, present the beat.
  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StValid
  } state_e;

endpackage

// File: rtl/axis_m.sv
// axis_m: single-beat AXI4-Stream master.
// A send request captures one word; the beat goes out one clock after send drops.
// Optional build macro AXIS_M_TLAST_EN: when defined, tlast follows tvalid so that
// every beat is marked last; when undefined, tlast is tied low.
module axis_m
  import axis_m_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  send,
  input  logic                  tready,
  output logic                  tvalid,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tlast,
  output logic                  finish
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  finish_q, finish_d;

  // Next-state and registered-output decode; outputs are computed one edge ahead.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    finish_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (send) begin
          word_d  = data;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (!send) begin
          state_d  = StValid;
          tvalid_d = 1'b1;
          tdata_d  = word_q;
        end
      end
      StValid: begin
        // send is deliberately ignored here, including on the handshake edge.
        if (tready) begin
          state_d  = StIdle;
          tvalid_d = 1'b0;
          finish_d = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a finish pulse.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q  <= StIdle;
      word_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      finish_q <= finish_d;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign finish = finish_q;

`ifdef AXIS_M_TLAST_EN
  logic tlast_q;

  // Every beat is a single-beat packet, so last tracks valid exactly.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tlast_q <= 1'b0;
    end else begin
      tlast_q <= tvalid_d;
    end
  end

  assign tlast = tlast_q;
`else
  assign tlast = 1'b0;
`endif

endmodule

// File: tb/tb_axis_m.sv
// Self-checking bench for axis_m: directed scenarios plus randomized transfers
// checked against a transaction-level model (queue of captured words).
module tb_axis_m;

  localparam int unsigned DW = 32;
`ifdef AXIS_M_TLAST_EN
  localparam bit TlastEn = 1'b1;
`else
  localparam bit TlastEn = 1'b0;
`endif

  logic          aclk;
  logic          areset_n;
  logic [DW-1:0] data;
  logic          send;
  logic          tready;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic          finish;

  int checks = 0;
  int errors = 0;

  // Reference model: words in capture order awaiting their beat.
  logic [DW-1:0] exp_q[$];

  axis_m #(
    .DATA_WIDTH(DW)
  ) dut (
    .aclk    (aclk),
    .areset_n(areset_n),
    .data    (data),
    .send    (send),
    .tready  (tready),
    .tvalid  (tvalid),
    .tdata   (tdata),
    .tlast   (tlast),
    .finish  (finish)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    send     = 1'b0;
    tready   = 1'b0;
    data     = '0;
    for (int i = 0; i < 5; i++) begin
      data   = $urandom;
      tready = 1'($urandom);
      tick();
      checks++;
      if ({tvalid, tlast, finish} !== 3'b000 || tdata !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d got v%0b l%0b f%0b d%h want zeros",
                 i, tvalid, tlast, finish, tdata);
      end
    end
    areset_n = 1'b1;
    tready   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tready = 1'($urandom);
      tick();
      checks++;
      if ({tvalid, tlast, finish} !== 3'b000 || tdata !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got v%0b l%0b f%0b d%h want zeros",
                 i, tvalid, tlast, finish, tdata);
      end
    end
    tready = 1'b0;
  endtask

  task automatic test_single();
    logic [DW-1:0] w;
    send = 1'b1;
    data = 32'hAAAA_BBBB;
    exp_q.push_back(data);
    tick();
    data = $urandom;
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_armed1 tvalid got %0b want 0", tvalid);
    end
    tick();
    send = 1'b0;
    data = $urandom;
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL single_armed2 tvalid got %0b want 0", tvalid);
    end
    tick();
    w = exp_q.pop_front();
    data = $urandom;
    checks++;
    if (tvalid !== 1'b1 || tdata !== w || tlast !== TlastEn || finish !== 1'b0) begin
      errors++;
      $display("FAIL single_valid got v%0b d%h l%0b f%0b want v1 d%h l%0b f0",
               tvalid, tdata, tlast, finish, w, TlastEn);
    end
    tready = 1'b1;
    tick();
    tready = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || finish !== 1'b1 || tdata !== w || tlast !== 1'b0) begin
      errors++;
      $display("FAIL single_hs got v%0b f%0b d%h l%0b want v0 f1 d%h l0",
               tvalid, finish, tdata, tlast, w);
    end
    tick();
    checks++;
    if (finish !== 1'b0 || tvalid !== 1'b0 || tdata !== w) begin
      errors++;
      $display("FAIL single_after got f%0b v%0b d%h want f0 v0 d%h",
               finish, tvalid, tdata, w);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] w;
    int            fin_cnt;
    send = 1'b1;
    data = $urandom;
    exp_q.push_back(data);
    tick();
    send = 1'b0;
    tick();
    w = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== w || finish !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall cyc %0d got v%0b d%h f%0b want v1 d%h f0",
                 i, tvalid, tdata, finish, w);
      end
      tready = 1'b0;
      tick();
    end
    tready  = 1'b1;
    fin_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tready = 1'b0;
      if (finish === 1'b1) fin_cnt++;
    end
    checks++;
    if (fin_cnt != 1 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release finish pulses got %0d want 1, tvalid got %0b want 0",
               fin_cnt, tvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w;
    send = 1'b1;
    data = $urandom;
    exp_q.push_back(data);
    tick();
    send = 1'b0;
    tick();
    w = exp_q.pop_front();
    // Half a cycle after tvalid rose: request the next word and accept the beat.
    #4;
    send   = 1'b1;
    data   = 32'hCCCC_DDDD;
    tready = 1'b1;
    tick();
    tready = 1'b0;
    checks++;
    if (tvalid !== 1'b0 || finish !== 1'b1 || tdata !== w) begin
      errors++;
      $display("FAIL b2b_hs got v%0b f%0b d%h want v0 f1 d%h", tvalid, finish, tdata, w);
    end
    exp_q.push_back(data);
    tick();
    send = 1'b0;
    data = $urandom;
    checks++;
    if (tvalid !== 1'b0 || finish !== 1'b0) begin
      errors++;
      $display("FAIL b2b_capture got v%0b f%0b want v0 f0", tvalid, finish);
    end
    tick();
    w = exp_q.pop_front();
    checks++;
    if (tvalid !== 1'b1 || tdata !== w || tlast !== TlastEn) begin
      errors++;
      $display("FAIL b2b_second got v%0b d%h l%0b want v1 d%h l%0b",
               tvalid, tdata, tlast, w, TlastEn);
    end
    tready = 1'b1;
    tick();
    tready = 1'b0;
    checks++;
    if (finish !== 1'b1 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hs2 got f%0b v%0b want f1 v0", finish, tvalid);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int seen;
    // Abort from VALID.
    send = 1'b1;
    data = $urandom;
    tick();
    send = 1'b0;
    tick();
    #2;
    areset_n = 1'b0;
    tready   = 1'b1;
    #1;
    checks++;
    if ({tvalid, tlast, finish} !== 3'b000 || tdata !== '0) begin
      errors++;
      $display("FAIL midrst_async got v%0b l%0b f%0b d%h want zeros",
               tvalid, tlast, finish, tdata);
    end
    tick();
    tick();
    areset_n = 1'b1;
    tready   = 1'b0;
    seen     = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (finish !== 1'b0 || tvalid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_valid_after got %0d active cycles want 0", seen);
    end
    // Abort from ARMED: dropping send afterwards must not produce a beat.
    send = 1'b1;
    data = $urandom;
    tick();
    #2;
    areset_n = 1'b0;
    #3;
    send = 1'b0;
    tick();
    areset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tvalid !== 1'b0 || finish !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || tdata !== '0) begin
      errors++;
      $display("FAIL midrst_armed got %0d active cycles d%h want 0 d0", seen, tdata);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] w;
    int            hold;
    int            stall;
    for (int n = 0; n < 25; n++) begin
      hold  = $urandom_range(1, 4);
      stall = $urandom_range(0, 3);
      send   = 1'b1;
      data   = $urandom;
      tready = 1'($urandom);
      exp_q.push_back(data);
      for (int i = 0; i < hold; i++) begin
        tick();
        data   = $urandom;
        tready = 1'($urandom);
        checks++;
        if (tvalid !== 1'b0 || finish !== 1'b0) begin
          errors++;
          $display("FAIL rnd_armed n%0d got v%0b f%0b want v0 f0", n, tvalid, finish);
        end
      end
      send = 1'b0;
      tick();
      w = exp_q.pop_front();
      for (int i = 0; i <= stall; i++) begin
        tready = (i == stall);
        data   = $urandom;
        checks++;
        if (tvalid !== 1'b1 || tdata !== w || tlast !== TlastEn || finish !== 1'b0) begin
          errors++;
          $display("FAIL rnd_valid n%0d got v%0b d%h l%0b f%0b want v1 d%h l%0b f0",
                   n, tvalid, tdata, tlast, finish, w, TlastEn);
        end
        tick();
      end
      tready = 1'b0;
      checks++;
      if (tvalid !== 1'b0 || finish !== 1'b1 || tdata !== w) begin
        errors++;
        $display("FAIL rnd_hs n%0d got v%0b f%0b d%h want v0 f1 d%h",
                 n, tvalid, finish, tdata, w);
      end
      tick();
      checks++;
      if (finish !== 1'b0 || tdata !== w) begin
        errors++;
        $display("FAIL rnd_post n%0d got f%0b d%h want f0 d%h", n, finish, tdata, w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
